// File: rtl/tidc_req_capture.sv
// Capture stage behind the TIDC A/C round-robin arbiter. It latches the granted master's
// Channel A or C message into an in-order FIFO and presents the head entry to the directory.
module tidc_req_capture #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int SRC_W  = 4,
  parameter int SZ_W   = 3,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         grant_valid,
  input  logic [1:0]                   grant_channel,
  input  logic                         grant_master,
  output logic                         grant_ready,
  input  logic [5:0]                   a_opcode_i,
  input  logic [5:0]                   a_param_i,
  input  logic [2*SZ_W-1:0]            a_size_i,
  input  logic [2*SRC_W-1:0]           a_source_i,
  input  logic [2*ADDR_W-1:0]          a_address_i,
  input  logic [2*DATA_W-1:0]          a_data_i,
  input  logic [2*(DATA_W/8)-1:0]      a_mask_i,
  input  logic [5:0]                   c_opcode_i,
  input  logic [5:0]                   c_param_i,
  input  logic [2*SZ_W-1:0]            c_size_i,
  input  logic [2*SRC_W-1:0]           c_source_i,
  input  logic [2*ADDR_W-1:0]          c_address_i,
  input  logic [2*DATA_W-1:0]          c_data_i,
  output logic                         req_valid,
  input  logic                         req_ready,
  output logic                         req_channel,
  output logic                         req_master,
  output logic [2:0]                   req_opcode,
  output logic [2:0]                   req_param,
  output logic [SZ_W-1:0]              req_size,
  output logic [SRC_W-1:0]             req_source,
  output logic [ADDR_W-1:0]            req_address,
  output logic [DATA_W-1:0]            req_data,
  output logic [DATA_W/8-1:0]          req_mask,
  output logic [$clog2(DEPTH)+1-1:0]   occupancy,
  output logic                         err_illegal_ch
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SZ_W-1:0]   size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } payload_t;

  typedef struct packed {
    logic     channel;
    logic     master;
    payload_t payload;
  } entry_t;

  payload_t aPayload [2];
  payload_t cPayload [2];

  // Channel C carries no byte mask, so its entries store a full-width mask.
  for (genvar m = 0; m < 2; m++) begin : g_slice
    assign aPayload[m] = {a_opcode_i[3*m +: 3], a_param_i[3*m +: 3],
                          a_size_i[SZ_W*m +: SZ_W], a_source_i[SRC_W*m +: SRC_W],
                          a_address_i[ADDR_W*m +: ADDR_W], a_data_i[DATA_W*m +: DATA_W],
                          a_mask_i[MASK_W*m +: MASK_W]};
    assign cPayload[m] = {c_opcode_i[3*m +: 3], c_param_i[3*m +: 3],
                          c_size_i[SZ_W*m +: SZ_W], c_source_i[SRC_W*m +: SRC_W],
                          c_address_i[ADDR_W*m +: ADDR_W], c_data_i[DATA_W*m +: DATA_W],
                          {MASK_W{1'b1}}};
  end

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              errIllegal_q, errIllegal_d;
  entry_t            pushEntry;
  entry_t            headEntry;
  logic              accept;
  logic              legalCh;
  logic              push;
  logic              pop;

  assign grant_ready = (count_q < CNT_W'(DEPTH));
  assign accept      = grant_valid && grant_ready;
  assign legalCh     = ~grant_channel[1];
  assign push        = accept && legalCh;
  assign req_valid   = (count_q != '0);
  assign pop         = req_valid && req_ready;

  always_comb begin
    pushEntry         = '0;
    pushEntry.channel = grant_channel[0];
    pushEntry.master  = grant_master;
    pushEntry.payload = grant_channel[0] ? cPayload[grant_master] : aPayload[grant_master];
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wrPtr_d      = wrPtr_q + PTR_W'(push);
    rdPtr_d      = rdPtr_q + PTR_W'(pop);
    count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
    errIllegal_d = errIllegal_q | (accept && !legalCh);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q      <= '0;
      rdPtr_q      <= '0;
      count_q      <= '0;
      errIllegal_q <= 1'b0;
    end else begin
      wrPtr_q      <= wrPtr_d;
      rdPtr_q      <= rdPtr_d;
      count_q      <= count_d;
      errIllegal_q <= errIllegal_d;
    end
  end

  // Storage is cleared on reset so the head payload reads as zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wrPtr_q] <= pushEntry;
    end
  end

  assign headEntry      = mem_q[rdPtr_q];
  assign req_channel    = headEntry.channel;
  assign req_master     = headEntry.master;
  assign req_opcode     = headEntry.payload.opcode;
  assign req_param      = headEntry.payload.param;
  assign req_size       = headEntry.payload.size;
  assign req_source     = headEntry.payload.source;
  assign req_address    = headEntry.payload.address;
  assign req_data       = headEntry.payload.data;
  assign req_mask       = headEntry.payload.mask;
  assign occupancy      = count_q;
  assign err_illegal_ch = errIllegal_q;

endmodule

// File: tb/tb_tidc_req_capture.sv
// Bench for tidc_req_capture: directed scenarios plus random traffic, all checked
// against a queue-based reference of the capture FIFO.
module tb_tidc_req_capture;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int SRC_W  = 4;
  localparam int SZ_W   = 3;
  localparam int DEPTH  = 2;
  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  grant_valid = 1'b0;
  logic [1:0]            grant_channel = 2'd0;
  logic                  grant_master = 1'b0;
  logic                  grant_ready;
  logic [5:0]            a_opcode, a_param, c_opcode, c_param;
  logic [2*SZ_W-1:0]     a_size, c_size;
  logic [2*SRC_W-1:0]    a_source, c_source;
  logic [2*ADDR_W-1:0]   a_address, c_address;
  logic [2*DATA_W-1:0]   a_data, c_data;
  logic [2*MASK_W-1:0]   a_mask;
  logic                  req_valid;
  logic                  req_ready = 1'b0;
  logic                  req_channel, req_master;
  logic [2:0]            req_opcode, req_param;
  logic [SZ_W-1:0]       req_size;
  logic [SRC_W-1:0]      req_source;
  logic [ADDR_W-1:0]     req_address;
  logic [DATA_W-1:0]     req_data;
  logic [MASK_W-1:0]     req_mask;
  logic [CNT_W-1:0]      occupancy;
  logic                  err_illegal_ch;

  typedef struct {
    logic              ch;
    logic              master;
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SZ_W-1:0]   size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
    logic [MASK_W-1:0] mask;
  } refEntry_t;

  refEntry_t refQ[$];
  logic      refErr = 1'b0;
  int        testCount = 0;
  int        failCount = 0;
  logic [MASK_W-1:0] savedMask;

  tidc_req_capture #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SRC_W(SRC_W), .SZ_W(SZ_W), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .grant_valid(grant_valid), .grant_channel(grant_channel),
    .grant_master(grant_master), .grant_ready(grant_ready),
    .a_opcode_i(a_opcode), .a_param_i(a_param), .a_size_i(a_size),
    .a_source_i(a_source), .a_address_i(a_address), .a_data_i(a_data),
    .a_mask_i(a_mask),
    .c_opcode_i(c_opcode), .c_param_i(c_param), .c_size_i(c_size),
    .c_source_i(c_source), .c_address_i(c_address), .c_data_i(c_data),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_channel(req_channel), .req_master(req_master),
    .req_opcode(req_opcode), .req_param(req_param), .req_size(req_size),
    .req_source(req_source), .req_address(req_address), .req_data(req_data),
    .req_mask(req_mask), .occupancy(occupancy), .err_illegal_ch(err_illegal_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic randomizeBuses();
    a_opcode  = 6'($urandom);
    a_param   = 6'($urandom);
    a_size    = (2*SZ_W)'($urandom);
    a_source  = (2*SRC_W)'($urandom);
    a_address = {$urandom, $urandom};
    a_data    = {$urandom, $urandom, $urandom, $urandom};
    a_mask    = (2*MASK_W)'($urandom);
    c_opcode  = 6'($urandom);
    c_param   = 6'($urandom);
    c_size    = (2*SZ_W)'($urandom);
    c_source  = (2*SRC_W)'($urandom);
    c_address = {$urandom, $urandom};
    c_data    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic checkOutput();
    refEntry_t h;
    check("grant_ready", grant_ready, (refQ.size() < DEPTH) ? 1 : 0);
    check("req_valid", req_valid, (refQ.size() != 0) ? 1 : 0);
    check("occupancy", occupancy, refQ.size());
    check("err_illegal_ch", err_illegal_ch, refErr);
    if (refQ.size() != 0) begin
      h = refQ[0];
      check("req_channel", req_channel, h.ch);
      check("req_master", req_master, h.master);
      check("req_opcode", req_opcode, h.opcode);
      check("req_param", req_param, h.param);
      check("req_size", req_size, h.size);
      check("req_source", req_source, h.source);
      check("req_address", req_address, h.address);
      check("req_data", req_data, h.data);
      check("req_mask", req_mask, h.mask);
    end
  endtask

  // Reference behaviour at a clock edge, computed from the pre-edge occupancy.
  task automatic updateModel();
    refEntry_t e;
    int  mi;
    bit  doPush;
    bit  doPop;
    doPush = 0;
    doPop  = (refQ.size() != 0) && req_ready;
    mi     = int'(grant_master);
    if (grant_valid && (refQ.size() < DEPTH)) begin
      if (grant_channel < 2) begin
        doPush   = 1;
        e.ch     = grant_channel[0];
        e.master = grant_master;
        if (grant_channel == 0) begin
          e.opcode  = a_opcode[3*mi +: 3];
          e.param   = a_param[3*mi +: 3];
          e.size    = a_size[SZ_W*mi +: SZ_W];
          e.source  = a_source[SRC_W*mi +: SRC_W];
          e.address = a_address[ADDR_W*mi +: ADDR_W];
          e.data    = a_data[DATA_W*mi +: DATA_W];
          e.mask    = a_mask[MASK_W*mi +: MASK_W];
        end else begin
          e.opcode  = c_opcode[3*mi +: 3];
          e.param   = c_param[3*mi +: 3];
          e.size    = c_size[SZ_W*mi +: SZ_W];
          e.source  = c_source[SRC_W*mi +: SRC_W];
          e.address = c_address[ADDR_W*mi +: ADDR_W];
          e.data    = c_data[DATA_W*mi +: DATA_W];
          e.mask    = '1;
        end
      end else begin
        refErr = 1'b1;
      end
    end
    if (doPop) void'(refQ.pop_front());
    if (doPush) refQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic gv, input logic [1:0] ch, input logic m, input logic rr);
    grant_valid   = gv;
    grant_channel = ch;
    grant_master  = m;
    req_ready     = rr;
    #1;
    checkOutput();
    @(posedge clk);
    updateModel();
    @(negedge clk);
  endtask

  initial begin
    randomizeBuses();
    repeat (2) @(negedge clk);
    #1;
    check("reset_req_valid", req_valid, 0);
    check("reset_occupancy", occupancy, 0);
    check("reset_err", err_illegal_ch, 0);
    check("reset_req_data", req_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_grant_ready", grant_ready, 1);
    @(negedge clk);

    // Single A grant from master 1
    randomizeBuses();
    a_opcode[5:3]     = 3'd4;
    a_address[63:32]  = 32'h0000_1000;
    a_source[7:4]     = 4'd3;
    savedMask         = a_mask[15:8];
    applyStimulus(1, 2'd0, 1, 0);
    randomizeBuses();
    #1;
    check("singleA_valid", req_valid, 1);
    check("singleA_channel", req_channel, 0);
    check("singleA_master", req_master, 1);
    check("singleA_opcode", req_opcode, 4);
    check("singleA_address", req_address, 32'h1000);
    check("singleA_source", req_source, 3);
    check("singleA_mask", req_mask, savedMask);
    applyStimulus(0, 2'd0, 0, 1);

    // C grant from master 0
    randomizeBuses();
    c_opcode[2:0]  = 3'd7;
    c_data[63:0]   = 64'hDEAD_BEEF_CAFE_F00D;
    applyStimulus(1, 2'd1, 0, 0);
    randomizeBuses();
    #1;
    check("c_channel", req_channel, 1);
    check("c_opcode", req_opcode, 7);
    check("c_data", req_data, 64'hDEAD_BEEF_CAFE_F00D);
    check("c_mask", req_mask, 8'hFF);
    applyStimulus(0, 2'd0, 0, 1);

    // Fill to full, third grant refused, then drain in order
    for (int i = 0; i < 3; i++) begin
      randomizeBuses();
      if (i == 2) check("fill_occ", occupancy, 2);
      applyStimulus(1, 2'(i % 2), 1'(i / 2), 0);
    end
    check("full_grant_ready", grant_ready, 0);
    for (int i = 0; i < 3; i++) begin
      randomizeBuses();
      applyStimulus(0, 2'd0, 0, 1);
    end
    check("drained_occ", occupancy, 0);

    // Full-throughput stream
    for (int i = 0; i < 8; i++) begin
      randomizeBuses();
      applyStimulus(1, 2'(i % 2), 1'((i / 2) % 2), 1);
      check("stream_occ", occupancy, 1);
    end
    applyStimulus(0, 2'd0, 0, 1);

    // Illegal channel with one entry held
    randomizeBuses();
    applyStimulus(1, 2'd0, 0, 0);
    randomizeBuses();
    applyStimulus(1, 2'd2, 1, 0);
    check("illegal_err", err_illegal_ch, 1);
    check("illegal_occ", occupancy, 1);
    for (int i = 0; i < 4; i++) begin
      randomizeBuses();
      applyStimulus(1'(i < 2), 2'(i % 2), 1'(i % 2), 1);
    end
    check("illegal_sticky", err_illegal_ch, 1);

    // Reset mid-stream with two entries held
    randomizeBuses();
    applyStimulus(0, 2'd0, 0, 1);
    applyStimulus(1, 2'd0, 0, 0);
    randomizeBuses();
    applyStimulus(1, 2'd1, 1, 0);
    check("pre_reset_occ", occupancy, 2);
    rst_n = 1'b0;
    #1;
    check("midreset_valid", req_valid, 0);
    check("midreset_occ", occupancy, 0);
    check("midreset_err", err_illegal_ch, 0);
    check("midreset_address", req_address, 0);
    refQ.delete();
    refErr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    randomizeBuses();
    applyStimulus(1, 2'd0, 1, 0);
    check("postreset_occ", occupancy, 1);
    applyStimulus(0, 2'd0, 0, 1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      randomizeBuses();
      applyStimulus(1'($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 15) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 2) != 0));
    end
    #1;
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
